// File: rtl/spi_master_param.sv
// Parametrised SPI master: per-transfer CPOL/CPHA, full-duplex, start/busy/done.
// Ports: start, d_in, ss_sel, cpol, cpha, miso in; sclk, mosi, ss, busy, done, d_out out.
module spi_master_param #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int NUM_SS    = 4,
  parameter int MSB_FIRST = 1,
  parameter int SSW       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] d_in,
  input  logic [SSW-1:0]    ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] d_out
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGES = EW'(2 * DATA_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     ecnt;
  logic [EW-1:0]     e_num;
  logic [DATA_W-1:0] shreg;
  logic              rx_bit;
  logic              cpol_q;
  logic              cpha_q;
  logic              tick;
  logic              lead;
  logic              last;
  logic              first_bit;
  logic              nxt_bit;
  logic [NUM_SS-1:0] sel_dec;

  // Shift one received bit in at the end opposite to the outgoing bit.
  function automatic logic [DATA_W-1:0] shift_in(
    input logic [DATA_W-1:0] r,
    input logic              b
  );
    if (MSB_FIRST != 0) return {r[DATA_W-2:0], b};
    else                return {b, r[DATA_W-1:1]};
  endfunction

  always_comb begin
    tick      = (cnt == DIV_LAST);
    e_num     = ecnt + EW'(1);
    lead      = e_num[0];
    last      = (e_num == EDGES);
    first_bit = (MSB_FIRST != 0) ? d_in[DATA_W-1] : d_in[0];
    nxt_bit   = (MSB_FIRST != 0) ? shreg[DATA_W-2] : shreg[1];
    sel_dec   = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (SSW'(i) == ss_sel) sel_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ecnt   <= '0;
      shreg  <= '0;
      rx_bit <= 1'b0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      ss     <= '1;
      busy   <= 1'b0;
      done   <= 1'b0;
      d_out  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          sclk <= cpol_q;
          mosi <= 1'b0;
          if (start) begin
            state  <= SETUP;
            cnt    <= '0;
            ecnt   <= '0;
            shreg  <= d_in;
            cpol_q <= cpol;
            cpha_q <= cpha;
            sclk   <= cpol;
            mosi   <= first_bit;
            ss     <= sel_dec;
            busy   <= 1'b1;
          end
        end
        SETUP, XFER: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            // One extra idle half-period follows the last edge.
            if (state == XFER && ecnt == EDGES) begin
              state <= HOLD;
            end else begin
              state <= XFER;
              ecnt  <= e_num;
              sclk  <= ~sclk;
              if (lead) begin
                if (!cpha_q) begin
                  rx_bit <= miso;
                end else if (ecnt != '0) begin
                  shreg <= shift_in(shreg, rx_bit);
                  mosi  <= nxt_bit;
                end
              end else if (!cpha_q) begin
                shreg <= shift_in(shreg, rx_bit);
                if (!last) mosi <= nxt_bit;
              end else if (last) begin
                shreg <= shift_in(shreg, miso);
              end else begin
                rx_bit <= miso;
              end
            end
          end
        end
        HOLD: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            state <= IDLE;
            ss    <= '1;
            busy  <= 1'b0;
            done  <= 1'b1;
            d_out <= shreg;
            mosi  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
